imem_responder: RTL
===================

Name: imem_responder

Overview:
- Instruction-memory responder at the far end of the fetch interface. The fetch stage drives proc2Imem_addr and proc2Imem_req; this block returns Imem2proc_data with a configurable fixed latency.
- Supports a squash (abort) on branch redirect and a program-load write port used by the testbench or boot loader.
- Sits between the fetch stage and the instruction storage array.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two.
- LATENCY, 2, cycles from request acceptance to Imem2proc_valid; legal range 1..15.
- NOP_INSTR, 32'h0000_0013, word returned for out-of-range fetches.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- proc2Imem_addr  input  32  fetch byte address; bits [1:0] ignored.
- proc2Imem_req  input  1  fetch request; accepted when Imem2proc_busy is low.
- proc2Imem_abort  input  1  squash the in-flight request (taken branch).
- load_en  input  1  program-load write strobe.
- load_addr  input  32  load byte address; bits [1:0] ignored.
- load_data  input  32  load word.
- Imem2proc_data  output  32  returned instruction; valid only with Imem2proc_valid.
- Imem2proc_valid  output  1  one-cycle response pulse.
- Imem2proc_busy  output  1  a request is in flight; a new request would not be accepted.
- Imem2proc_error  output  1  qualifies a response whose address was out of range.

Behaviour:
- Reset (synchronous, rst high at posedge):
  - state = IDLE; counter = 0.
  - Imem2proc_data = 0, Imem2proc_valid = 0, Imem2proc_busy = 0, Imem2proc_error = 0.
  - Array contents are not cleared.
  - Reset mid-operation drops any in-flight request; no response is produced.
- Word index = addr[31:2]. Out of range when index >= DEPTH_WORDS; compare on the full 30-bit index, no wrap.
- States:
  - IDLE: idle.
  - WAIT: counter counting down.
  - RESP: Imem2proc_valid = 1 for exactly one cycle.
- Acceptance:
  - A request is accepted when proc2Imem_req = 1 and state ∈ {IDLE, RESP}.
  - On acceptance, the array word (or NOP_INSTR with the error flag if out of range) is captured into a hold register.
  - Later load writes do not alter a captured response.
- Latency: request accepted at edge t → Imem2proc_valid = 1 during the cycle after edge t+LATENCY-1.
  - LATENCY = 1: IDLE/RESP → RESP directly.
  - Otherwise: → WAIT with counter = LATENCY-1; decrement each cycle; → RESP when counter reaches 1.
- Back-to-back: a request accepted while in RESP chains immediately, giving throughput of 1 per LATENCY cycles.
- Imem2proc_busy = (state == WAIT), combinational from state.
- RESP with no new request → IDLE.
- Abort:
  - proc2Imem_abort = 1 while in WAIT → IDLE at next edge; no valid produced.
  - Abort in RESP suppresses nothing; the response is already presented.
  - Abort together with req in IDLE/RESP: the new request is accepted (abort only targets older requests).
  - Abort in IDLE is a no-op.
- Load port:
  - load_en writes load_data to load_addr at posedge when in range; out-of-range writes are dropped silently.
  - Writes are allowed in any state.
  - A same-cycle write and accepted read to the same word returns the old word (read-before-write).
- Imem2proc_data holds its last value when valid is low; Imem2proc_error is 0 whenever valid is 0.

Optional Feature:
- Macro: IMEM_STATS_EN.
- When defined, adds three outputs:
  - stat_req_cnt [31:0]: accepted requests.
  - stat_abort_cnt [31:0]: aborts that killed a WAIT request.
  - stat_err_cnt [31:0]: error responses.
- All counters clear on rst and saturate at 32'hFFFF_FFFF.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package imem_pkg: state enum imem_state_t {IDLE, WAIT, RESP}; constant IMEM_NOP = 32'h0000_0013; function word_index(addr).
- Sub-module imem_array: DEPTH_WORDS × 32 storage with synchronous write and combinational read, read-before-write on the same port cycle.
- Top level holds the FSM, counter, hold register and stats.

Test Plan:
- LATENCY=2: load 0x100 ← 32'hDEAD_BEEF; req addr 0x100 at edge t → valid=1, data=DEADBEEF, error=0 after edge t+1; busy=1 for one cycle.
- LATENCY=1: reqs on 0x0, 0x4, 0x8 in consecutive cycles → three consecutive valid pulses in order; busy never asserts.
- LATENCY=3: req 0x10, abort two cycles later → no valid; busy falls the cycle after abort; a next req is then accepted normally.
- DEPTH_WORDS=1024: req addr 0x1000 → valid with data=0x00000013, error=1; a load to 0x1000 leaves word 0 unchanged.
- Same-cycle load 0x20 ← 0x1111_1111 (old 0x2222_2222) and req 0x20 → response 0x22222222; next req 0x20 → 0x11111111.
- Assert rst while in WAIT → no valid; all outputs 0 next cycle; with IMEM_STATS_EN, counters read 0.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg: shared state encoding, default NOP word and address helper for the instruction-memory responder
package imem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} imem_state_t;
  localparam logic [31:0] IMEM_NOP = 32'h0000_0013;
  function automatic logic [29:0] word_index(input logic [31:0] addr);
    return addr[31:2];
  endfunction
endpackage

// File: rtl/imem_array.sv
// imem_array: word storage with synchronous write and combinational read (read sees the pre-write word)
module imem_array #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem_q [DEPTH_WORDS];
  always_ff @(posedge clk) if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/imem_responder.sv
// imem_responder: fixed-latency instruction fetch responder with abort and load port; IMEM_STATS_EN adds counters
module imem_responder
  import imem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] NOP_INSTR   = IMEM_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] proc2Imem_addr,
  input  logic        proc2Imem_req,
  input  logic        proc2Imem_abort,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic [31:0] Imem2proc_data,
  output logic        Imem2proc_valid,
  output logic        Imem2proc_busy,
  output logic        Imem2proc_error
`ifdef IMEM_STATS_EN
  ,
  output logic [31:0] stat_req_cnt,
  output logic [31:0] stat_abort_cnt,
  output logic [31:0] stat_err_cnt
`endif
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  imem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hold_q, hold_d, data_q, data_d, arr_rdata, rd_word;
  logic        hold_err_q, hold_err_d, err_q, err_d;
  logic [29:0] rd_idx, wr_idx;
  logic        rd_oob, accept;
  assign rd_idx  = word_index(proc2Imem_addr);
  assign wr_idx  = word_index(load_addr);
  assign rd_oob  = rd_idx >= 30'(DEPTH_WORDS);
  assign rd_word = rd_oob ? NOP_INSTR : arr_rdata;
  assign accept  = proc2Imem_req && state_q != WAIT;
  imem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .we    (load_en && wr_idx < 30'(DEPTH_WORDS)),
    .waddr (wr_idx[AW-1:0]),
    .wdata (load_data),
    .raddr (rd_idx[AW-1:0]),
    .rdata (arr_rdata)
  );
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    hold_err_d = hold_err_q;
    if (accept) begin
      hold_d     = rd_word;
      hold_err_d = rd_oob;
      state_d    = LATENCY == 1 ? RESP : WAIT;
      cnt_d      = CNT_INIT;
    end else if (state_q == WAIT) begin
      state_d = proc2Imem_abort ? IDLE : (cnt_q == 4'd1 ? RESP : WAIT);
      cnt_d   = cnt_q - 4'd1;
    end else state_d = IDLE;
    // output word only moves when a response is presented, so it holds while valid is low
    data_d = state_d == RESP ? hold_d : data_q;
    err_d  = state_d == RESP && hold_err_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hold_q     <= '0;
      hold_err_q <= 1'b0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      hold_err_q <= hold_err_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end
  assign Imem2proc_data  = data_q;
  assign Imem2proc_valid = state_q == RESP;
  assign Imem2proc_busy  = state_q == WAIT;
  assign Imem2proc_error = err_q;
`ifdef IMEM_STATS_EN
  logic [31:0] req_cnt_q, req_cnt_d, abort_cnt_q, abort_cnt_d, err_cnt_q, err_cnt_d;
  always_comb begin
    req_cnt_d   = req_cnt_q + 32'(accept && req_cnt_q != '1);
    abort_cnt_d = abort_cnt_q + 32'(state_q == WAIT && proc2Imem_abort && abort_cnt_q != '1);
    err_cnt_d   = err_cnt_q + 32'(err_d && err_cnt_q != '1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      req_cnt_q   <= '0;
      abort_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      req_cnt_q   <= req_cnt_d;
      abort_cnt_q <= abort_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end
  assign stat_req_cnt   = req_cnt_q;
  assign stat_abort_cnt = abort_cnt_q;
  assign stat_err_cnt   = err_cnt_q;
`endif
endmodule
